// File: rtl/apb4_regfile_pkg.sv
// Shared types and width helpers for the APB4 register-file completer.
package apb4_regfile_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_UNALIGNED,
    ERR_RANGE,
    ERR_RO_WRITE,
    ERR_PRIV
  } err_cause_t;

  localparam int unsigned WAIT_CNT_W = 4;

  // Number of byte-offset bits inside one data word.
  function automatic int unsigned lane_bits(input int unsigned n_bit_data);
    return $clog2(n_bit_data / 8);
  endfunction

  // Width of the word index carried by the upper address bits.
  function automatic int unsigned index_bits(input int unsigned n_bit_address,
                                             input int unsigned n_bit_data);
    return n_bit_address - lane_bits(n_bit_data);
  endfunction

endpackage

// File: rtl/apb4_wait_counter.sv
// Wait-state down-counter: loaded at setup, decremented during the access phase.
module apb4_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/apb4_regfile_slave.sv
// APB4 completer: word register bank with byte strobes, read-only status slots,
// privilege checking and a fixed number of wait states per access.
module apb4_regfile_slave
  import apb4_regfile_pkg::*;
#(
  parameter int                     N_BIT_DATA    = 32,
  parameter int                     N_BIT_ADDRESS = 8,
  parameter int                     N_REGISTERS   = 16,
  parameter int                     WAIT_STATES   = 0,
  parameter logic [N_REGISTERS-1:0] RO_MASK       = '0,
  parameter logic [N_REGISTERS-1:0] PRIV_MASK     = '0
) (
  input  logic                              PCLK,
  input  logic                              PRESETn,
  input  logic                              PSEL,
  input  logic                              PENABLE,
  input  logic                              PWRITE,
  input  logic [N_BIT_ADDRESS-1:0]          PADDR,
  input  logic [N_BIT_DATA-1:0]             PWDATA,
  input  logic [N_BIT_DATA/8-1:0]           PSTRB,
  input  logic [2:0]                        PPROT,
  output logic [N_BIT_DATA-1:0]             PRDATA,
  output logic                              PREADY,
  output logic                              PSLVERR,
  input  logic [N_REGISTERS*N_BIT_DATA-1:0] STATUS,
  output logic [N_REGISTERS*N_BIT_DATA-1:0] CONTROL
);

  localparam int unsigned NBYTES    = N_BIT_DATA / 8;
  localparam int unsigned NREG      = N_REGISTERS;
  localparam int unsigned LANE_BITS = lane_bits(N_BIT_DATA);
  localparam int unsigned IDXW      = index_bits(N_BIT_ADDRESS, N_BIT_DATA);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  state_t                state_q, state_d;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic                  access, xfer_err, wr_en;
  logic                  unaligned, sel_ro, sel_priv;
  logic [IDXW-1:0]       idx;
  logic [N_BIT_DATA-1:0] rd_word;
  logic [N_BIT_DATA-1:0] regs [NREG];
  err_cause_t            err_cause;
  logic                  unused_prot;

  assign unused_prot = ^PPROT[2:1];

  apb4_wait_counter #(
    .WIDTH(WAIT_CNT_W)
  ) u_wait (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .load      (cnt_load),
    .load_value(WAIT_LOAD),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ACCESS;
          cnt_load = 1'b1;
        end
      end
      ACCESS: begin
        if (!PSEL || PREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx = PADDR[N_BIT_ADDRESS-1:LANE_BITS];

  if (LANE_BITS > 0) begin : g_align
    assign unaligned = |PADDR[LANE_BITS-1:0];
  end else begin : g_no_align
    assign unaligned = 1'b0;
  end

  // Index compare per slot keeps out-of-range addresses from selecting anything.
  always_comb begin
    sel_ro   = 1'b0;
    sel_priv = 1'b0;
    rd_word  = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (idx == IDXW'(i)) begin
        sel_ro   = RO_MASK[i];
        sel_priv = PRIV_MASK[i];
        rd_word  = RO_MASK[i] ? STATUS[i*N_BIT_DATA +: N_BIT_DATA] : regs[i];
      end
    end
  end

  always_comb begin
    if (unaligned)                 err_cause = ERR_UNALIGNED;
    else if (32'(idx) >= NREG)     err_cause = ERR_RANGE;
    else if (PWRITE && sel_ro)     err_cause = ERR_RO_WRITE;
    else if (!PPROT[0] && sel_priv) err_cause = ERR_PRIV;
    else                           err_cause = ERR_NONE;
  end

  assign access   = (state_q == ACCESS);
  assign xfer_err = (err_cause != ERR_NONE);
  assign cnt_dec  = access && PSEL && !cnt_zero;
  assign PREADY   = access && PSEL && cnt_zero;
  assign PSLVERR  = PREADY && xfer_err;
  assign PRDATA   = (PREADY && !xfer_err && !PWRITE) ? rd_word : '0;
  assign wr_en    = PREADY && PENABLE && PWRITE && !xfer_err;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        for (int unsigned k = 0; k < NBYTES; k++) begin
          if ((idx == IDXW'(i)) && !RO_MASK[i] && PSTRB[k]) begin
            regs[i][k*8 +: 8] <= PWDATA[k*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    CONTROL = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      CONTROL[i*N_BIT_DATA +: N_BIT_DATA] = RO_MASK[i] ? '0 : regs[i];
    end
  end

endmodule

// File: tb/tb_apb4_regfile_slave.sv
// Directed bench for apb4_regfile_slave: one completer with no wait states and one with three.
module tb_apb4_regfile_slave;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic         psel0, psel1, penable, pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic [511:0] status;
  logic [31:0]  prdata0, prdata1;
  logic         pready0, pready1, pslverr0, pslverr1;
  logic [511:0] control0, control1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb4_regfile_slave #(
    .N_BIT_DATA(32), .N_BIT_ADDRESS(8), .N_REGISTERS(16), .WAIT_STATES(0),
    .RO_MASK(16'h0004), .PRIV_MASK(16'h0008)
  ) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata0),
    .PREADY(pready0), .PSLVERR(pslverr0), .STATUS(status), .CONTROL(control0)
  );

  apb4_regfile_slave #(
    .N_BIT_DATA(32), .N_BIT_ADDRESS(8), .N_REGISTERS(16), .WAIT_STATES(3),
    .RO_MASK(16'h0004), .PRIV_MASK(16'h0008)
  ) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel1), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata1),
    .PREADY(pready1), .PSLVERR(pslverr1), .STATUS(status), .CONTROL(control1)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Full APB transfer; cyc counts setup plus access cycles up to the one with PREADY high.
  task automatic xfer(input bit d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr,
                      output logic [31:0] rd, output logic err, output int cyc);
    bit done = 1'b0;
    paddr = a; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr; penable = 1'b0;
    if (d) psel1 = 1'b1; else psel0 = 1'b1;
    cyc = 1; rd = '0; err = 1'b0;
    @(posedge PCLK); #1 penable = 1'b1;
    for (int n = 0; n < 32 && !done; n++) begin
      @(negedge PCLK);
      cyc++;
      if (d ? pready1 : pready0) begin
        rd   = d ? prdata1 : prdata0;
        err  = d ? pslverr1 : pslverr0;
        done = 1'b1;
      end
      @(posedge PCLK); #1;
    end
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL xfer_timeout: got no PREADY expected PREADY within 32 cycles");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          cyc;
    bit          done;

    PRESETn = 1'b0;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    status = '0;
    for (int i = 0; i < 16; i++) status[i*32 +: 32] = 32'h5000_0000 | 32'(i);
    status[2*32 +: 32] = 32'hA5A5_A5A5;

    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready0", {31'b0, pready0}, 32'h0);
    check("rst_pready1", {31'b0, pready1}, 32'h0);
    check("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
    check("rst_prdata0", prdata0, 32'h0);
    check("rst_control0", {31'b0, |control0}, 32'h0);
    check("rst_control1", {31'b0, |control1}, 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // WAIT_STATES=0: full write then read of word 1
    xfer(0, 1, 8'h04, 32'hDEAD_BEEF, 4'hF, 3'b000, rd, err, cyc);
    check("w04_err", {31'b0, err}, 32'h0);
    check("w04_cycles", 32'(cyc), 32'd2);
    check("w04_control1", control0[32 +: 32], 32'hDEAD_BEEF);
    xfer(0, 0, 8'h04, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("r04_data", rd, 32'hDEAD_BEEF);
    check("r04_err", {31'b0, err}, 32'h0);
    check("r04_cycles", 32'(cyc), 32'd2);

    vecs.push_back('{1, 8'h04, 32'h1122_3344, 4'b0101, 3'b000, 32'h0,         1'b0});
    vecs.push_back('{0, 8'h04, 32'h0,         4'h0,    3'b000, 32'hDE22_BE44, 1'b0});
    vecs.push_back('{1, 8'h08, 32'h1234_5678, 4'hF,    3'b000, 32'h0,         1'b1});
    vecs.push_back('{0, 8'h08, 32'h0,         4'h0,    3'b000, 32'hA5A5_A5A5, 1'b0});
    vecs.push_back('{1, 8'h0C, 32'hCAFE_F00D, 4'hF,    3'b000, 32'h0,         1'b1});
    vecs.push_back('{0, 8'h0C, 32'h0,         4'h0,    3'b000, 32'h0,         1'b1});
    vecs.push_back('{1, 8'h0C, 32'hCAFE_F00D, 4'hF,    3'b001, 32'h0,         1'b0});
    vecs.push_back('{0, 8'h0C, 32'h0,         4'h0,    3'b001, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{0, 8'h02, 32'h0,         4'h0,    3'b000, 32'h0,         1'b1});
    vecs.push_back('{1, 8'h40, 32'hFFFF_FFFF, 4'hF,    3'b000, 32'h0,         1'b1});
    vecs.push_back('{0, 8'h40, 32'h0,         4'h0,    3'b000, 32'h0,         1'b1});
    vecs.push_back('{1, 8'h04, 32'hFFFF_FFFF, 4'h0,    3'b000, 32'h0,         1'b0});
    vecs.push_back('{0, 8'h04, 32'h0,         4'h0,    3'b000, 32'hDE22_BE44, 1'b0});
    vecs.push_back('{1, 8'h3C, 32'h89AB_CDEF, 4'b0011, 3'b000, 32'h0,         1'b0});
    vecs.push_back('{0, 8'h3C, 32'h0,         4'h0,    3'b000, 32'h0000_CDEF, 1'b0});
    vecs.push_back('{1, 8'h06, 32'hFFFF_FFFF, 4'hF,    3'b000, 32'h0,         1'b1});
    vecs.push_back('{0, 8'h04, 32'h0,         4'h0,    3'b000, 32'hDE22_BE44, 1'b0});
    vecs.push_back('{0, 8'h00, 32'h0,         4'h0,    3'b000, 32'h0,         1'b0});
    vecs.push_back('{0, 8'h10, 32'h0,         4'h0,    3'b000, 32'h0,         1'b0});

    foreach (vecs[i]) begin
      xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].prot, rd, err, cyc);
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'd2);
      if (!vecs[i].wr || vecs[i].exp_err)
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    check("ctrl0_w0", control0[0*32 +: 32], 32'h0);
    check("ctrl0_w1", control0[1*32 +: 32], 32'hDE22_BE44);
    check("ctrl0_w2", control0[2*32 +: 32], 32'h0);
    check("ctrl0_w3", control0[3*32 +: 32], 32'hCAFE_F00D);
    check("ctrl0_w4", control0[4*32 +: 32], 32'h0);
    check("ctrl0_w15", control0[15*32 +: 32], 32'h0000_CDEF);
    check("idle_pready0", {31'b0, pready0}, 32'h0);

    // WAIT_STATES=3: 3 low cycles then ready; back-to-back transfers
    xfer(1, 0, 8'h00, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("ws3_r00_cycles", 32'(cyc), 32'd5);
    check("ws3_r00_data", rd, 32'h0);
    xfer(1, 1, 8'h00, 32'h55AA_55AA, 4'hF, 3'b000, rd, err, cyc);
    check("ws3_b2b_w_cycles", 32'(cyc), 32'd5);
    check("ws3_b2b_w_err", {31'b0, err}, 32'h0);
    xfer(1, 0, 8'h00, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("ws3_b2b_r_cycles", 32'(cyc), 32'd5);
    check("ws3_b2b_r_data", rd, 32'h55AA_55AA);
    check("ws3_ctrl_w0", control1[0*32 +: 32], 32'h55AA_55AA);
    xfer(1, 1, 8'h08, 32'h1, 4'hF, 3'b000, rd, err, cyc);
    check("ws3_ro_err", {31'b0, err}, 32'h1);
    check("ws3_ro_cycles", 32'(cyc), 32'd5);

    // PSEL dropped after one access cycle: no write, no error, FSM back to IDLE
    paddr = 8'h00; pwrite = 1'b1; pwdata = 32'h7777_7777; pstrb = 4'hF; pprot = 3'b000;
    psel1 = 1'b1; penable = 1'b0;
    @(posedge PCLK); #1 penable = 1'b1;
    @(posedge PCLK); #1 psel1 = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    check("abort_pslverr", {31'b0, pslverr1}, 32'h0);
    check("abort_pready", {31'b0, pready1}, 32'h0);
    @(posedge PCLK); #1;
    xfer(1, 0, 8'h00, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("abort_next_cycles", 32'(cyc), 32'd5);
    check("abort_no_write", rd, 32'h55AA_55AA);

    // Reset asserted in the completing cycle of a read: outputs clear at once
    paddr = 8'h00; pwrite = 1'b0; pstrb = 4'h0; pprot = 3'b000;
    psel1 = 1'b1; penable = 1'b0;
    @(posedge PCLK); #1 penable = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge PCLK);
      if (pready1) done = 1'b1;
    end
    check("rstmid_ready_seen", {31'b0, done}, 32'h1);
    check("rstmid_pre_data", prdata1, 32'h55AA_55AA);
    #1 PRESETn = 1'b0;
    #1;
    check("rstmid_pready", {31'b0, pready1}, 32'h0);
    check("rstmid_pslverr", {31'b0, pslverr1}, 32'h0);
    check("rstmid_prdata", prdata1, 32'h0);
    check("rstmid_control1", {31'b0, |control1}, 32'h0);
    check("rstmid_control0", {31'b0, |control0}, 32'h0);
    psel1 = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1, 0, 8'h00, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("post_rst_r00", rd, 32'h0);
    check("post_rst_cycles", 32'(cyc), 32'd5);
    xfer(1, 1, 8'h10, 32'h1357_2468, 4'hF, 3'b000, rd, err, cyc);
    xfer(1, 0, 8'h10, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("post_rst_r10", rd, 32'h1357_2468);
    xfer(0, 0, 8'h04, 32'h0, 4'h0, 3'b000, rd, err, cyc);
    check("post_rst_dut0_r04", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
